// File: rtl/packet_pkg.sv
//------------------------------------------------------------------------------
// packet_pkg
// Shared packet geometry for the switch ingress path.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package packet_pkg;
  localparam int PACKET_WIDTH = 16;
  localparam int DEPTH        = 8;
  localparam int HDR_W        = 8;
endpackage

`default_nettype wire

// File: rtl/ingress_fifo_ring_ptr.sv
//------------------------------------------------------------------------------
// ring_ptr
// Modulo-DEPTH pointer with increment and synchronous clear.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ring_ptr
  import packet_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] ptr_q;

  // Explicit wrap so non-power-of-two depths stay in range.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

`default_nettype wire

// File: rtl/ingress_fifo.sv
//------------------------------------------------------------------------------
// ingress_fifo
// Per-port input queue with FWFT/registered read, thresholds and drop counter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ingress_fifo
  import packet_pkg::*;
#(
  parameter  int DATA_W    = PACKET_WIDTH,
  parameter  int DEPTH     = packet_pkg::DEPTH,
  parameter  int HDR_W     = packet_pkg::HDR_W,
  parameter  bit FWFT      = 1'b0,
  parameter  int AFULL_TH  = DEPTH - 1,
  parameter  int AEMPTY_TH = 1,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr_en,
  output logic              fifo_full,
  output logic              almost_full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              fifo_empty,
  output logic              almost_empty,
  output logic [HDR_W-1:0]  header_out,
  output logic              header_valid,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow,
  output logic [15:0]       drop_cnt
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);

  if (DEPTH < 2 || HDR_W > DATA_W || AEMPTY_TH < 1 ||
      AEMPTY_TH >= AFULL_TH || AFULL_TH > DEPTH) begin : g_param_check
    $error("ingress_fifo: illegal DEPTH/HDR_W/threshold parameters");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_d,     count_q;
  logic              overflow_d,  overflow_q;
  logic              underflow_d, underflow_q;
  logic [15:0]       drop_cnt_d,  drop_cnt_q;
  logic              wr_acc;
  logic              rd_acc;

  // Gates use the registered flags, so a full FIFO rejects a same-cycle write.
  assign wr_acc = wr_en && !fifo_full  && !flush;
  assign rd_acc = rd_en && !fifo_empty && !flush;

  ring_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_acc),
    .clr (flush),
    .ptr (wr_ptr)
  );

  ring_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_acc),
    .clr (flush),
    .ptr (rd_ptr)
  );

  always_comb begin
    count_d     = count_q;
    overflow_d  = wr_en && fifo_full  && !flush;
    underflow_d = rd_en && fifo_empty && !flush;
    drop_cnt_d  = drop_cnt_q;
    if (flush) begin
      count_d = '0;
    end else if (wr_acc && !rd_acc) begin
      count_d = count_q + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - 1'b1;
    end
    if (overflow_d && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr] <= data_in;
    end
  end

  if (FWFT) begin : g_fwft
    assign data_out   = fifo_empty ? '0 : mem_q[rd_ptr];
    assign data_valid = !fifo_empty;
  end else begin : g_reg_read
    logic [DATA_W-1:0] data_out_d,   data_out_q;
    logic              data_valid_d, data_valid_q;

    always_comb begin
      data_out_d   = rd_acc ? mem_q[rd_ptr] : data_out_q;
      data_valid_d = rd_acc;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        data_out_q   <= '0;
        data_valid_q <= 1'b0;
      end else begin
        data_out_q   <= data_out_d;
        data_valid_q <= data_valid_d;
      end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
  end

  assign fifo_full    = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AFULL_C);
  assign fifo_empty   = (count_q == '0);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign header_out   = fifo_empty ? '0 : mem_q[rd_ptr][HDR_W-1:0];
  assign header_valid = !fifo_empty;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign drop_cnt     = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ingress_fifo.sv
//------------------------------------------------------------------------------
// tb_ingress_fifo
// Directed bench for ingress_fifo: registered-read and FWFT instances, DEPTH=5.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ingress_fifo;

  localparam int DW = 16;
  localparam int D  = 5;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] data_in = '0;

  logic          full_r, afull_r, empty_r, aempty_r, dv_r, hv_r, ovf_r, unf_r;
  logic [DW-1:0] dout_r;
  logic [7:0]    hdr_r;
  logic [CW-1:0] cnt_r;
  logic [15:0]   drop_r;

  logic          full_f, afull_f, empty_f, aempty_f, dv_f, hv_f, ovf_f, unf_f;
  logic [DW-1:0] dout_f;
  logic [7:0]    hdr_f;
  logic [CW-1:0] cnt_f;
  logic [15:0]   drop_f;

  always #5 clk = ~clk;

  ingress_fifo #(.DATA_W(DW), .DEPTH(D), .HDR_W(8), .FWFT(1'b0)) u_reg (
    .clk(clk), .rst(rst), .flush(flush), .data_in(data_in), .wr_en(wr_en),
    .fifo_full(full_r), .almost_full(afull_r), .rd_en(rd_en), .data_out(dout_r),
    .data_valid(dv_r), .fifo_empty(empty_r), .almost_empty(aempty_r),
    .header_out(hdr_r), .header_valid(hv_r), .count(cnt_r), .overflow(ovf_r),
    .underflow(unf_r), .drop_cnt(drop_r)
  );

  ingress_fifo #(.DATA_W(DW), .DEPTH(D), .HDR_W(8), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .data_in(data_in), .wr_en(wr_en),
    .fifo_full(full_f), .almost_full(afull_f), .rd_en(rd_en), .data_out(dout_f),
    .data_valid(dv_f), .fifo_empty(empty_f), .almost_empty(aempty_f),
    .header_out(hdr_f), .header_valid(hv_f), .count(cnt_f), .overflow(ovf_f),
    .underflow(unf_f), .drop_cnt(drop_f)
  );

  logic [DW-1:0] mdl[$];
  logic [DW-1:0] sb[$];
  logic [DW-1:0] exp_dout_r = '0;
  logic [15:0]   exp_drop   = '0;
  logic          exp_ovf    = 1'b0;
  logic          exp_unf    = 1'b0;
  logic          exp_dv_r   = 1'b0;
  int            n_pass     = 0;
  int            n_total    = 0;
  int            step_no    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s step %0d observed=0x%0h expected=0x%0h", tag, step_no, obs, exp);
  endtask

  task automatic check_all();
    int            n;
    logic [DW-1:0] head;
    n    = mdl.size();
    head = (n != 0) ? mdl[0] : '0;
    if (dv_r === 1'b1) begin
      if (sb.size() == 0) chk("r_unexpected_valid", 32'(dv_r), 32'd0);
      else exp_dout_r = sb.pop_front();
    end
    chk("r_count",        32'(cnt_r),    32'(n));
    chk("r_fifo_full",    32'(full_r),   32'(n == D));
    chk("r_almost_full",  32'(afull_r),  32'(n >= D - 1));
    chk("r_fifo_empty",   32'(empty_r),  32'(n == 0));
    chk("r_almost_empty", 32'(aempty_r), 32'(n <= 1));
    chk("r_header_out",   32'(hdr_r),    32'(head[7:0]));
    chk("r_header_valid", 32'(hv_r),     32'(n != 0));
    chk("r_overflow",     32'(ovf_r),    32'(exp_ovf));
    chk("r_underflow",    32'(unf_r),    32'(exp_unf));
    chk("r_drop_cnt",     32'(drop_r),   32'(exp_drop));
    chk("r_data_valid",   32'(dv_r),     32'(exp_dv_r));
    chk("r_data_out",     32'(dout_r),   32'(exp_dout_r));
    chk("f_count",        32'(cnt_f),    32'(n));
    chk("f_data_out",     32'(dout_f),   32'(head));
    chk("f_data_valid",   32'(dv_f),     32'(n != 0));
    chk("f_header_out",   32'(hdr_f),    32'(head[7:0]));
    chk("f_overflow",     32'(ovf_f),    32'(exp_ovf));
    chk("f_underflow",    32'(unf_f),    32'(exp_unf));
    chk("f_drop_cnt",     32'(drop_f),   32'(exp_drop));
  endtask

  // One clock of stimulus; the reference queue is updated from pre-edge state.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic f, input logic rs);
    bit full, empty, wacc, racc;
    wr_en = w; data_in = d; rd_en = r; flush = f; rst = rs;
    step_no++;
    if (rs) begin
      mdl.delete(); sb.delete();
      exp_drop = '0; exp_ovf = 1'b0; exp_unf = 1'b0;
      exp_dv_r = 1'b0; exp_dout_r = '0;
    end else begin
      full     = (mdl.size() == D);
      empty    = (mdl.size() == 0);
      wacc     = w && !full && !f;
      racc     = r && !empty && !f;
      exp_ovf  = w && full && !f;
      exp_unf  = r && empty && !f;
      exp_dv_r = racc;
      if (racc) sb.push_back(mdl.pop_front());
      if (f) mdl.delete();
      if (wacc) mdl.push_back(d);
      if (exp_ovf && exp_drop != 16'hFFFF) exp_drop++;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    // Fill, then one rejected write.
    for (int i = 1; i <= 5; i++) step(1'b1, 16'(i * 16'h11), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0066, 1'b0, 1'b0, 1'b0);
    // Drain plus one rejected read.
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    // Wrap-around with steady occupancy.
    for (int i = 0; i < 3; i++) step(1'b1, 16'(16'h0101 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 16'(16'h0200 + i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    // Single-entry fall-through.
    step(1'b1, 16'h00A7, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    // Full with simultaneous write and read.
    for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h0301 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h03FF, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    // Empty with simultaneous write and read.
    step(1'b1, 16'h0400, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    // Flush with concurrent write, then confirm pointers restart cleanly.
    for (int i = 0; i < 3; i++) step(1'b1, 16'(16'h0501 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h05AA, 1'b1, 1'b1, 1'b0);
    step(1'b1, 16'h0600, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    // Reset mid-operation, together with flush and requests.
    for (int i = 0; i < 2; i++) step(1'b1, 16'(16'h0701 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h07FF, 1'b1, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
